// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU control decode, forwarding and load-use detection
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [15:0]   id_imm,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] word1,
  output logic [DW-1:0] word2,
  output logic [1:0]    ALUOp,
  output logic          bitinvert,
  output logic          ex_valid,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_branch,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_stall,
  output logic          illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  logic          r_valid;
  logic [1:0]    r_aluop;
  logic          r_bitinv;
  logic [RW-1:0] r_dest;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_branch;
  logic          r_alusrc;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [DW-1:0] r_rs_val;
  logic [DW-1:0] r_rt_val;
  logic [DW-1:0] r_imm;
  logic          r_illegal;

  logic          w_ok;
  logic [1:0]    w_aluop;
  logic          w_bitinv;
  logic [RW-1:0] w_dest;
  logic          w_regwrite;
  logic          w_memread;
  logic          w_memwrite;
  logic          w_branch;
  logic          w_alusrc;
  logic          w_reads_rt;
  logic [DW-1:0] w_imm;
  logic          w_load_use;
  logic          w_advance;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  always_comb begin
    w_ok       = 1'b1;
    w_aluop    = ALU_ADD;
    w_bitinv   = 1'b0;
    w_dest     = id_rt;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_alusrc   = 1'b0;
    w_reads_rt = 1'b0;
    w_imm      = {{(DW-16){id_imm[15]}}, id_imm};
    case (id_opcode)
      OP_RTYPE: begin
        w_dest     = id_rd;
        w_regwrite = 1'b1;
        w_reads_rt = 1'b1;
        case (id_funct)
          6'h20, 6'h21: w_aluop = ALU_ADD;
          6'h22, 6'h23: w_bitinv = 1'b1;
          6'h24:        w_aluop = ALU_AND;
          6'h25:        w_aluop = ALU_OR;
          default:      w_ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_ANDI: begin
        w_aluop    = ALU_AND;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_imm      = {{(DW-16){1'b0}}, id_imm};
      end
      OP_ORI: begin
        w_aluop    = ALU_OR;
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_imm      = {{(DW-16){1'b0}}, id_imm};
      end
      OP_LW: begin
        w_alusrc   = 1'b1;
        w_memread  = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_SW: begin
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
        w_reads_rt = 1'b1;
      end
      OP_BEQ: begin
        w_bitinv   = 1'b1;
        w_branch   = 1'b1;
        w_reads_rt = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
  end

  // rt only counts as a hazard source for instructions that actually read it
  assign w_load_use = r_valid && r_memread && (r_dest != '0) &&
                      ((r_dest == id_rs) || ((r_dest == id_rt) && w_reads_rt));
  assign w_advance  = !flush && !stall && !w_load_use;

  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] reg_a,
    input logic [DW-1:0] reg_v,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_res,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_res
  );
    if (em_we && (em_rd == reg_a) && (reg_a != '0)) return em_res;
    else if (mw_we && (mw_rd == reg_a) && (reg_a != '0)) return mw_res;
    else return reg_v;
  endfunction

  assign w_fwd_rs = fwd(r_rs, r_rs_val, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
  assign w_fwd_rt = fwd(r_rt, r_rt_val, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_aluop    <= '0;
      r_bitinv   <= 1'b0;
      r_dest     <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_val   <= '0;
      r_rt_val   <= '0;
      r_imm      <= '0;
      r_illegal  <= 1'b0;
    end else if (!stall || flush) begin
      if (w_advance && id_valid && w_ok) begin
        r_valid    <= 1'b1;
        r_aluop    <= w_aluop;
        r_bitinv   <= w_bitinv;
        r_dest     <= w_dest;
        r_regwrite <= w_regwrite;
        r_memread  <= w_memread;
        r_memwrite <= w_memwrite;
        r_branch   <= w_branch;
        r_alusrc   <= w_alusrc;
        r_rs       <= id_rs;
        r_rt       <= id_rt;
        r_rs_val   <= id_rs_val;
        r_rt_val   <= id_rt_val;
        r_imm      <= w_imm;
      end else begin
        r_valid    <= 1'b0;
        r_aluop    <= '0;
        r_bitinv   <= 1'b0;
        r_dest     <= '0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_branch   <= 1'b0;
        r_alusrc   <= 1'b0;
        r_rs       <= '0;
        r_rt       <= '0;
        r_rs_val   <= '0;
        r_rt_val   <= '0;
        r_imm      <= '0;
      end
      if (w_advance && id_valid && !w_ok) r_illegal <= 1'b1;
    end
  end

  assign word1          = w_fwd_rs;
  assign word2          = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data  = w_fwd_rt;
  assign ALUOp          = r_aluop;
  assign bitinvert      = r_bitinv;
  assign ex_valid       = r_valid;
  assign ex_dest        = r_dest;
  assign ex_regwrite    = r_regwrite;
  assign ex_memread     = r_memread;
  assign ex_memwrite    = r_memwrite;
  assign ex_branch      = r_branch;
  assign load_use_stall = w_load_use;
  assign illegal_op     = r_illegal;

endmodule
